// File: rtl/bf16_subtractor_if.sv
`default_nettype none
// ============================================================================
// bf16_subtractor_if : operand/result bundle for bf16_subtractor. Rev 1.0
// ============================================================================
interface bf16_subtractor_if;
    logic [15:0] a;
    logic [15:0] b;
    logic        start;
    logic        ready;
    logic        done;
    logic [15:0] diff;
    logic        overflow;
    logic        underflow;
    logic        invalid;

    modport master (
        output a, b, start,
        input  ready, done, diff, overflow, underflow, invalid
    );

    modport slave (
        input  a, b, start,
        output ready, done, diff, overflow, underflow, invalid
    );
endinterface
`default_nettype wire

// File: rtl/bf16_subtractor.sv
`default_nettype none
// ============================================================================
// bf16_subtractor : multi-cycle bfloat16 diff = a - b, round-nearest-even. Rev 1.0
// ============================================================================
module bf16_subtractor #(
    parameter int GRS_BITS    = 3,
    parameter int ALIGN_LIMIT = 11
) (
    input  wire logic        clock,
    input  wire logic        reset,
    bf16_subtractor_if.slave bus
);
    // significand layout: carry | hidden | 7 fraction | GRS
    localparam int          SW            = GRS_BITS + 9;
    localparam logic [7:0]  c_ALIGN_LIMIT = 8'(ALIGN_LIMIT);
    localparam logic [9:0]  c_EXP_MAX     = 10'd255;
    localparam logic [15:0] c_QNAN        = 16'h7FC0;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_UNPACK  = 3'd1,
        S_ALIGN   = 3'd2,
        S_OPERATE = 3'd3,
        S_NORM    = 3'd4,
        S_ROUND   = 3'd5,
        S_FINISH  = 3'd6
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [15:0]   r_a, r_b, w_a_nxt, w_b_nxt;
    logic          r_sx, w_sx_nxt, r_sub, w_sub_nxt;
    logic [9:0]    r_ex, w_ex_nxt;
    logic [7:0]    r_ediff, w_ediff_nxt;
    logic [SW-1:0] r_sig_x, r_sig_y, w_sig_x_nxt, w_sig_y_nxt;
    logic [15:0]   r_diff, w_diff_nxt;
    logic          r_ovf, r_unf, r_inv, r_done;
    logic          w_ovf_nxt, w_unf_nxt, w_inv_nxt, w_done_nxt;

    logic          w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_b_larger;
    logic [SW-1:0] w_sum;
    logic          w_up;
    logic [8:0]    w_mant;
    logic [9:0]    w_exr;

    assign w_a_zero   = (r_a[14:7] == 8'h00);
    assign w_b_zero   = (r_b[14:7] == 8'h00);
    assign w_a_inf    = (r_a[14:7] == 8'hFF) && (r_a[6:0] == 7'h00);
    assign w_b_inf    = (r_b[14:7] == 8'hFF) && (r_b[6:0] == 7'h00);
    assign w_a_nan    = (r_a[14:7] == 8'hFF) && (r_a[6:0] != 7'h00);
    assign w_b_nan    = (r_b[14:7] == 8'hFF) && (r_b[6:0] != 7'h00);
    assign w_b_larger = (r_b[14:0] > r_a[14:0]);

    // X is never smaller than Y, so the subtraction cannot go negative
    assign w_sum  = r_sub ? (r_sig_x - r_sig_y) : (r_sig_x + r_sig_y);

    assign w_up   = r_sig_x[GRS_BITS-1] & ((|r_sig_x[GRS_BITS-2:0]) | r_sig_x[GRS_BITS]);
    assign w_mant = {1'b0, r_sig_x[SW-2:GRS_BITS]} + {8'b0, w_up};
    assign w_exr  = r_ex + {9'b0, w_mant[8]};

    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_sx_nxt    = r_sx;
        w_sub_nxt   = r_sub;
        w_ex_nxt    = r_ex;
        w_ediff_nxt = r_ediff;
        w_sig_x_nxt = r_sig_x;
        w_sig_y_nxt = r_sig_y;
        w_diff_nxt  = r_diff;
        w_ovf_nxt   = r_ovf;
        w_unf_nxt   = r_unf;
        w_inv_nxt   = r_inv;
        w_done_nxt  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_a_nxt     = bus.a;
                    w_b_nxt     = bus.b;
                    w_ovf_nxt   = 1'b0;
                    w_unf_nxt   = 1'b0;
                    w_inv_nxt   = 1'b0;
                    w_state_nxt = S_UNPACK;
                end
            end
            S_UNPACK: begin
                w_state_nxt = S_FINISH;
                if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (r_a[15] == r_b[15]))) begin
                    w_diff_nxt = c_QNAN;
                    w_inv_nxt  = 1'b1;
                end else if (w_a_inf) begin
                    w_diff_nxt = r_a;
                end else if (w_b_inf) begin
                    w_diff_nxt = {~r_b[15], r_b[14:0]};
                end else if (w_a_zero && w_b_zero) begin
                    w_diff_nxt = {r_a[15] & ~r_b[15], 15'h0000};
                end else if (w_a_zero) begin
                    w_diff_nxt = {~r_b[15], r_b[14:0]};
                end else if (w_b_zero) begin
                    w_diff_nxt = r_a;
                end else begin
                    w_sub_nxt   = (r_a[15] == r_b[15]);
                    w_sx_nxt    = w_b_larger ? ~r_b[15] : r_a[15];
                    w_ex_nxt    = {2'b00, (w_b_larger ? r_b[14:7] : r_a[14:7])};
                    w_ediff_nxt = w_b_larger ? (r_b[14:7] - r_a[14:7]) : (r_a[14:7] - r_b[14:7]);
                    w_sig_x_nxt = {2'b01, (w_b_larger ? r_b[6:0] : r_a[6:0]), {GRS_BITS{1'b0}}};
                    w_sig_y_nxt = {2'b01, (w_b_larger ? r_a[6:0] : r_b[6:0]), {GRS_BITS{1'b0}}};
                    w_state_nxt = S_ALIGN;
                end
            end
            S_ALIGN: begin
                if (r_ediff >= c_ALIGN_LIMIT) begin
                    w_sig_y_nxt = {{(SW-1){1'b0}}, |r_sig_y};
                    w_state_nxt = S_OPERATE;
                end else if (r_ediff == 8'd0) begin
                    w_state_nxt = S_OPERATE;
                end else begin
                    w_sig_y_nxt = {1'b0, r_sig_y[SW-1:2], r_sig_y[1] | r_sig_y[0]};
                    w_ediff_nxt = r_ediff - 8'd1;
                    if (r_ediff == 8'd1) begin
                        w_state_nxt = S_OPERATE;
                    end
                end
            end
            S_OPERATE: begin
                if (w_sum == '0) begin
                    w_diff_nxt  = 16'h0000;
                    w_state_nxt = S_FINISH;
                end else begin
                    w_sig_x_nxt = w_sum;
                    w_state_nxt = S_NORM;
                end
            end
            S_NORM: begin
                if (r_sig_x[SW-1]) begin
                    w_sig_x_nxt = {1'b0, r_sig_x[SW-1:2], r_sig_x[1] | r_sig_x[0]};
                    w_ex_nxt    = r_ex + 10'd1;
                    w_state_nxt = S_ROUND;
                end else if (!r_sig_x[SW-2]) begin
                    if (r_ex <= 10'd1) begin
                        w_diff_nxt  = {r_sx, 15'h0000};
                        w_unf_nxt   = 1'b1;
                        w_state_nxt = S_FINISH;
                    end else begin
                        w_sig_x_nxt = {r_sig_x[SW-2:0], 1'b0};
                        w_ex_nxt    = r_ex - 10'd1;
                    end
                end else begin
                    w_state_nxt = S_ROUND;
                end
            end
            S_ROUND: begin
                if (w_exr >= c_EXP_MAX) begin
                    w_diff_nxt = {r_sx, 8'hFF, 7'h00};
                    w_ovf_nxt  = 1'b1;
                end else begin
                    w_diff_nxt = {r_sx, w_exr[7:0], w_mant[6:0]};
                end
                w_state_nxt = S_FINISH;
            end
            S_FINISH: begin
                w_done_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sx    <= 1'b0;
            r_sub   <= 1'b0;
            r_ex    <= '0;
            r_ediff <= '0;
            r_sig_x <= '0;
            r_sig_y <= '0;
            r_diff  <= 16'h0000;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_inv   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_sx    <= w_sx_nxt;
            r_sub   <= w_sub_nxt;
            r_ex    <= w_ex_nxt;
            r_ediff <= w_ediff_nxt;
            r_sig_x <= w_sig_x_nxt;
            r_sig_y <= w_sig_y_nxt;
            r_diff  <= w_diff_nxt;
            r_ovf   <= w_ovf_nxt;
            r_unf   <= w_unf_nxt;
            r_inv   <= w_inv_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign bus.ready     = (r_state == S_IDLE);
    assign bus.done      = r_done;
    assign bus.diff      = r_diff;
    assign bus.overflow  = r_ovf;
    assign bus.underflow = r_unf;
    assign bus.invalid   = r_inv;
endmodule
`default_nettype wire

// File: tb/tb_bf16_subtractor.sv
`default_nettype none
// ============================================================================
// tb_bf16_subtractor : scoreboard bench for bf16_subtractor against a real-valued model. Rev 1.0
// ============================================================================
module tb_bf16_subtractor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bf16_subtractor_if bus ();

    bf16_subtractor #(.GRS_BITS(3), .ALIGN_LIMIT(11)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    // flags = {overflow, underflow, invalid}
    typedef struct {
        logic [15:0] diff;
        logic [2:0]  flags;
        logic        special;
        int          t0;
        int          tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   lat;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Reference: exact value via double precision, then round-nearest-even into bf16
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        exp_t        r;
        logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, up;
        real         va, vb, vd;
        logic [63:0] bits;
        logic [52:0] m;
        logic [8:0]  k;
        logic [44:0] rem, half;
        int          e;
        r.diff = 16'h0000; r.flags = 3'b000; r.special = 1'b1; r.t0 = 0; r.tag = 0;
        a_zero = (a[14:7] == 8'h00);
        b_zero = (b[14:7] == 8'h00);
        a_inf  = (a[14:7] == 8'hFF) && (a[6:0] == 7'h00);
        b_inf  = (b[14:7] == 8'hFF) && (b[6:0] == 7'h00);
        a_nan  = (a[14:7] == 8'hFF) && (a[6:0] != 7'h00);
        b_nan  = (b[14:7] == 8'hFF) && (b[6:0] != 7'h00);
        if (a_nan || b_nan || (a_inf && b_inf && a[15] == b[15])) begin
            r.diff = 16'h7FC0; r.flags = 3'b001;
        end else if (a_inf) begin
            r.diff = a;
        end else if (b_inf) begin
            r.diff = {~b[15], b[14:0]};
        end else if (a_zero && b_zero) begin
            r.diff = {a[15] & ~b[15], 15'h0000};
        end else if (a_zero) begin
            r.diff = {~b[15], b[14:0]};
        end else if (b_zero) begin
            r.diff = a;
        end else begin
            r.special = 1'b0;
            va = $bitstoreal({a[15], 11'(a[14:7]) + 11'd896, a[6:0], 45'b0});
            vb = $bitstoreal({b[15], 11'(b[14:7]) + 11'd896, b[6:0], 45'b0});
            vd = va - vb;
            if (vd != 0.0) begin
                bits = $realtobits(vd);
                e    = int'(bits[62:52]) - 896;
                if (e < 1) begin
                    r.diff  = {bits[63], 15'h0000};
                    r.flags = 3'b010;
                end else begin
                    m    = {1'b1, bits[51:0]};
                    k    = {1'b0, m[52:45]};
                    rem  = m[44:0];
                    half = '0;
                    half[44] = 1'b1;
                    up = (rem > half) || ((rem == half) && k[0]);
                    k  = k + {8'b0, up};
                    if (k[8]) e = e + 1;
                    if (e >= 255) begin
                        r.diff  = {bits[63], 8'hFF, 7'h00};
                        r.flags = 3'b100;
                    end else begin
                        r.diff = {bits[63], 8'(e), k[6:0]};
                    end
                end
            end
        end
        return r;
    endfunction

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input exp_t e, input bit push);
        int   n;
        exp_t x;
        x = e;
        n = 0;
        @(negedge clk);
        while (!bus.ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ready) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout actual=busy required=ready tag=%0d", e.tag);
        end
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        x.t0      = cyc;
        if (push) sb.push_back(x);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic directed(input logic [15:0] a, input logic [15:0] b, input logic [15:0] d,
                            input logic [2:0] f, input logic sp, input int tag);
        exp_t e;
        e.diff = d; e.flags = f; e.special = sp; e.t0 = 0; e.tag = tag;
        issue(a, b, e, 1'b1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", sb.size());
            sb.delete();
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_done actual=done diff=%h required=no_done", bus.diff);
            end else begin
                mon_e = sb.pop_front();
                lat   = cyc - mon_e.t0;
                chk($sformatf("diff[%0d]", mon_e.tag), 32'(bus.diff), 32'(mon_e.diff));
                chk($sformatf("flags[%0d]", mon_e.tag),
                    32'({bus.overflow, bus.underflow, bus.invalid}), 32'(mon_e.flags));
                chk($sformatf("ready_with_done[%0d]", mon_e.tag), 32'(bus.ready), 32'd1);
                if (mon_e.special) chk($sformatf("special_latency[%0d]", mon_e.tag), 32'(lat), 32'd3);
                else               chk($sformatf("latency_le_26[%0d]", mon_e.tag), 32'(lat <= 26), 32'd1);
            end
        end
    end

    initial begin
        logic [15:0] ra, rb;
        logic [7:0]  ea;
        int          eb;
        exp_t        e;
        bus.a = 16'h0000; bus.b = 16'h0000; bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", 32'(bus.ready), 32'd1);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_diff", 32'(bus.diff), 32'h0000);
        chk("reset_flags", 32'({bus.overflow, bus.underflow, bus.invalid}), 32'd0);

        directed(16'h3F80, 16'h3F80, 16'h0000, 3'b000, 1'b0, 0);
        directed(16'h4040, 16'h3F80, 16'h4000, 3'b000, 1'b0, 1);
        directed(16'h3F80, 16'hBF80, 16'h4000, 3'b000, 1'b0, 2);
        directed(16'h3F80, 16'h3FC0, 16'hBF00, 3'b000, 1'b0, 3);
        directed(16'h3F80, 16'h3B00, 16'h3F80, 3'b000, 1'b0, 4);
        directed(16'h7F80, 16'h7F80, 16'h7FC0, 3'b001, 1'b1, 5);
        directed(16'h3F80, 16'hFF80, 16'h7F80, 3'b000, 1'b1, 6);
        directed(16'hFFC1, 16'h0000, 16'h7FC0, 3'b001, 1'b1, 7);
        directed(16'h7F7F, 16'hFF7F, 16'h7F80, 3'b100, 1'b0, 8);
        directed(16'h0080, 16'h0081, 16'h8000, 3'b010, 1'b0, 9);
        directed(16'h8000, 16'h0000, 16'h8000, 3'b000, 1'b1, 10);
        drain();

        for (int i = 0; i < 300; i++) begin
            ea = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3))
               : ($urandom_range(0, 3) == 0) ? 8'($urandom_range(252, 254))
               : 8'($urandom_range(1, 254));
            ra = {1'($urandom_range(0, 1)), ea, 7'($urandom_range(0, 127))};
            case ($urandom_range(0, 3))
                0: rb = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 7'($urandom_range(0, 127))};
                3: rb = {1'($urandom_range(0, 1)), ra[14:7], ($urandom_range(0, 1) == 1) ? ra[6:0] : 7'($urandom_range(0, 127))};
                default: begin
                    eb = int'(ea) + int'($urandom_range(0, 2)) - 1;
                    if (eb < 1) eb = 1;
                    if (eb > 254) eb = 254;
                    rb = {1'($urandom_range(0, 1)), 8'(eb), 7'($urandom_range(0, 127))};
                end
            endcase
            if ($urandom_range(0, 11) == 0) begin
                case ($urandom_range(0, 6))
                    0: ra = 16'h0000; 1: ra = 16'h8000; 2: ra = 16'h7F80; 3: ra = 16'hFF80;
                    4: ra = 16'h7FC0; 5: ra = 16'hFFC1; default: ra = 16'h0005;
                endcase
            end
            if ($urandom_range(0, 11) == 0) begin
                case ($urandom_range(0, 6))
                    0: rb = 16'h0000; 1: rb = 16'h8000; 2: rb = 16'h7F80; 3: rb = 16'hFF80;
                    4: rb = 16'hFFC1; 5: rb = ra; default: rb = 16'h8003;
                endcase
            end
            e     = model(ra, rb);
            e.tag = 100 + i;
            issue(ra, rb, e, 1'b1);
        end
        drain();

        // Abort an operation while it is normalizing; its result must never appear
        directed(16'h3F80, 16'h3FC0, 16'hBF00, 3'b000, 1'b0, 20);
        drain();
        e = model(16'h3F80, 16'h3FC0);
        issue(16'h3F80, 16'h3FC0, e, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midop_reset_ready", 32'(bus.ready), 32'd1);
        chk("midop_reset_done", 32'(bus.done), 32'd0);
        chk("midop_reset_diff", 32'(bus.diff), 32'h0000);
        chk("midop_reset_flags", 32'({bus.overflow, bus.underflow, bus.invalid}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        directed(16'h4040, 16'h3F80, 16'h4000, 3'b000, 1'b0, 21);

        // Start while busy is ignored: no extra done, operands untouched
        directed(16'h3F80, 16'h3B00, 16'h3F80, 3'b000, 1'b0, 22);
        chk("ready_fall_after_accept", 32'(bus.ready), 32'd0);
        bus.a = 16'h7F80; bus.b = 16'h7F80; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        drain();
        repeat (40) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
